// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment scan controller:
// segment patterns, dash/blank constants and converter states.
package ssd_pkg;

  // Converter FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } conv_state_t;

  // Segment patterns, order {a,b,c,d,e,f,g}, active-low.
  localparam logic [6:0] SEG_DASH  = 7'b1111110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Hex nibble to active-low segment pattern {a..g}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter. One bit per clock:
// adjust every BCD digit >= 5 by +3, then shift left. A 1 leaving the
// top digit flags that the value does not fit in NUM_DIGITS digits.
module bin2bcd_seq
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  localparam int VW = 4 * NUM_DIGITS,
  localparam int CW = $clog2(VW)
) (
  input  logic          ClkPort,
  input  logic          Reset,
  input  logic          start,
  input  logic [VW-1:0] value,
  output logic          busy,
  output logic          done,
  output logic [VW-1:0] bcd,
  output logic          overflow
);

  conv_state_t   state_reg;
  logic [VW-1:0] bin_reg;
  logic [VW-1:0] bcd_reg;
  logic [CW-1:0] cnt_reg;
  logic          ovf_reg;
  logic          busy_reg;
  logic          done_reg;
  logic [VW-1:0] adj;

  // Per-digit +3 correction applied before each shift.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
    assign adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                            bcd_reg[4*gi +: 4] + 4'd3 : bcd_reg[4*gi +: 4];
  end

  // Converter FSM; busy/done are registered alongside the state.
  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      state_reg <= IDLE;
      bin_reg   <= '0;
      bcd_reg   <= '0;
      cnt_reg   <= '0;
      ovf_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            bin_reg   <= value;
            bcd_reg   <= '0;
            cnt_reg   <= '0;
            ovf_reg   <= 1'b0;
            busy_reg  <= 1'b1;
            state_reg <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_reg <= {adj[VW-2:0], bin_reg[VW-1]};
          bin_reg <= {bin_reg[VW-2:0], 1'b0};
          ovf_reg <= ovf_reg | adj[VW-1];
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CW'(VW - 1)) begin
            done_reg  <= 1'b1;
            state_reg <= COMMIT;
          end
        end
        COMMIT: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign bcd      = bcd_reg;
  assign overflow = ovf_reg;

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Multi-digit seven-segment scan controller: value capture (hex or
// decimal via bin2bcd_seq), digit scanning, leading-zero blanking,
// blink, decimal points and overflow dashes. An/Cath go straight to pins.
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int SCAN_DIV_BITS  = 18,
  parameter int BLINK_DIV_BITS = 26,
  localparam int VW = 4 * NUM_DIGITS,
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                  ClkPort,
  input  logic                  Reset,
  input  logic [VW-1:0]         value,
  input  logic                  load,
  input  logic                  mode_bcd,
  input  logic                  blank_lz,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  input  logic [NUM_DIGITS-1:0] blink_mask,
  output logic                  busy,
  output logic [NUM_DIGITS-1:0] An,
  output logic [7:0]            Cath
);

  logic [VW-1:0]            disp_reg;
  logic                     ovf_reg;
  logic [SCAN_DIV_BITS-1:0] scan_cnt_reg;
  logic [IW-1:0]            idx_reg;
  logic [BLINK_DIV_BITS:0]  blink_cnt_reg;
  logic [NUM_DIGITS-1:0]    an_reg, an_next;
  logic [7:0]               cath_reg, cath_next;

  logic          conv_start, conv_busy, conv_done, conv_ovf;
  logic [VW-1:0] conv_bcd;
  logic          accept;

  // A load is only honoured while no conversion is running.
  assign accept     = load & ~conv_busy;
  assign conv_start = accept & mode_bcd;

  bin2bcd_seq #(.NUM_DIGITS(NUM_DIGITS)) u_bin2bcd (
    .ClkPort  (ClkPort),
    .Reset    (Reset),
    .start    (conv_start),
    .value    (value),
    .busy     (conv_busy),
    .done     (conv_done),
    .bcd      (conv_bcd),
    .overflow (conv_ovf)
  );

  // Display register: hex loads land immediately, BCD results on commit.
  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      disp_reg <= '0;
      ovf_reg  <= 1'b0;
    end else if (conv_done) begin
      disp_reg <= conv_bcd;
      ovf_reg  <= conv_ovf;
    end else if (accept && !mode_bcd) begin
      disp_reg <= value;
      ovf_reg  <= 1'b0;
    end
  end

  // Dwell prescaler and digit index, wrapping at NUM_DIGITS-1.
  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      scan_cnt_reg <= '0;
      idx_reg      <= '0;
    end else begin
      scan_cnt_reg <= scan_cnt_reg + 1'b1;
      if (scan_cnt_reg == '1)
        idx_reg <= (idx_reg == IW'(NUM_DIGITS - 1)) ? '0 : idx_reg + 1'b1;
    end
  end

  // Blink phase is the top bit of a free-running counter.
  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) blink_cnt_reg <= '0;
    else       blink_cnt_reg <= blink_cnt_reg + 1'b1;
  end

  // Per-digit nibble and "something nonzero at or above this digit".
  logic [3:0]            digit_nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] shown;
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign digit_nib[gi] = disp_reg[4*gi +: 4];
    if (gi == 0) begin : g_lsd
      assign shown[gi] = 1'b1;
    end else begin : g_upper
      assign shown[gi] = |disp_reg[VW-1:4*gi];
    end
  end

  // Next anode/cathode pair for the current index.
  always_comb begin
    logic off;
    off = (blank_lz & ~ovf_reg & ~shown[idx_reg]) |
          (blink_cnt_reg[BLINK_DIV_BITS] & blink_mask[idx_reg]);
    an_next   = off ? '1 : ~(NUM_DIGITS'(1) << idx_reg);
    cath_next = {(ovf_reg ? SEG_DASH : hex_to_seg(digit_nib[idx_reg])),
                 ~dp_mask[idx_reg]};
  end

  // Anodes and cathodes change on the same edge, never skewed.
  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      an_reg   <= '1;
      cath_reg <= 8'hFF;
    end else begin
      an_reg   <= an_next;
      cath_reg <= cath_next;
    end
  end

  assign An   = an_reg;
  assign Cath = cath_reg;
  assign busy = conv_busy;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Self-checking bench for ssd_scan_ctrl: an 8-digit and a 5-digit
// instance, directed vector table, hand sequences and random loads
// checked against a digit-arithmetic display model.
module tb_ssd_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] value;
  logic        load8, load5, mode_bcd, blank_lz;
  logic [7:0]  dp_mask, blink_mask;
  logic        busy8, busy5;
  logic [7:0]  an8, cath8, cath5;
  logic [4:0]  an5;

  int checks = 0;
  int errors = 0;
  int n = 0;

  logic [31:0] exp_disp8 = 0, exp_disp5 = 0;
  bit          exp_ovf8 = 0, exp_ovf5 = 0;

  logic [6:0] seg_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                               7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  always #5 clk = ~clk;

  // Clock edges since reset release.
  always @(posedge clk or posedge rst) begin
    if (rst) n <= 0;
    else     n <= n + 1;
  end

  ssd_scan_ctrl #(.NUM_DIGITS(8), .SCAN_DIV_BITS(2), .BLINK_DIV_BITS(4)) dut8 (
    .ClkPort(clk), .Reset(rst), .value(value), .load(load8), .mode_bcd(mode_bcd),
    .blank_lz(blank_lz), .dp_mask(dp_mask), .blink_mask(blink_mask),
    .busy(busy8), .An(an8), .Cath(cath8));

  ssd_scan_ctrl #(.NUM_DIGITS(5), .SCAN_DIV_BITS(2), .BLINK_DIV_BITS(4)) dut5 (
    .ClkPort(clk), .Reset(rst), .value(value[19:0]), .load(load5), .mode_bcd(mode_bcd),
    .blank_lz(blank_lz), .dp_mask(dp_mask[4:0]), .blink_mask(blink_mask[4:0]),
    .busy(busy5), .An(an5), .Cath(cath5));

  task automatic check8(string nm, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (edge %0d)", nm, act, exp, n);
    end
  endtask

  task automatic check_int(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Decimal digits of v packed as nibbles, lowest nd digits only.
  function automatic logic [31:0] to_bcd(longint v, int nd);
    logic [31:0] r = 0;
    longint p = 1;
    for (int i = 0; i < nd; i++) begin
      r |= 32'((v / p) % 10) << (4 * i);
      p *= 10;
    end
    return r;
  endfunction

  // Expected {An, Cath} seen after edge `ne` for an nd-digit display.
  function automatic logic [15:0] model_out(int nd, logic [31:0] disp, bit ovf, int ne);
    int m = ne - 1;
    int idx = (m / 4) % nd;
    bit phase = ((m / 16) % 2) == 1;
    int h = 0;
    bit off;
    logic [7:0] an = 8'hFF;
    logic [6:0] seg;
    for (int i = 0; i < nd; i++)
      if (disp[4*i +: 4] != 0) h = i;
    off = (blank_lz && !ovf && idx > h) || (phase && blink_mask[idx]);
    if (!off) an[idx] = 1'b0;
    seg = ovf ? 7'b1111110 : seg_tab[disp[4*idx +: 4]];
    return {an, seg, ~dp_mask[idx]};
  endfunction

  // Load a value into one instance, check busy length, update the model.
  task automatic do_load(bit use5, bit mode, logic [31:0] v, bit blz,
                         logic [7:0] dp, logic [7:0] bl);
    int cnt = 0;
    longint vv;
    @(negedge clk);
    mode_bcd = mode; value = v; blank_lz = blz; dp_mask = dp; blink_mask = bl;
    if (use5) load5 = 1'b1; else load8 = 1'b1;
    @(negedge clk);
    load5 = 1'b0; load8 = 1'b0;
    if (mode) begin
      while ((use5 ? busy5 : busy8) && cnt < 100) begin
        cnt++;
        @(negedge clk);
      end
      check_int(use5 ? "busy_len5" : "busy_len8", cnt, use5 ? 21 : 33);
    end else begin
      check8("hex_busy", {7'd0, use5 ? busy5 : busy8}, 8'd0);
    end
    repeat (2) @(negedge clk);
    vv = use5 ? longint'(v[19:0]) : longint'(v);
    if (use5) begin
      exp_ovf5  = mode && vv >= 100000;
      exp_disp5 = mode ? to_bcd(vv, 5) : 32'(vv);
    end else begin
      exp_ovf8  = mode && vv >= 100000000;
      exp_disp8 = mode ? to_bcd(vv, 8) : 32'(vv);
    end
  endtask

  // Compare every cycle of a window against the model.
  task automatic scan_check(bit use5, int cycles, string nm);
    logic [15:0] e;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (use5) begin
        e = model_out(5, exp_disp5, exp_ovf5, n);
        check8({nm, "_an"}, {3'b111, an5}, e[15:8]);
        check8({nm, "_cath"}, cath5, e[7:0]);
      end else begin
        e = model_out(8, exp_disp8, exp_ovf8, n);
        check8({nm, "_an"}, an8, e[15:8]);
        check8({nm, "_cath"}, cath8, e[7:0]);
      end
    end
  endtask

  // Advance until the outputs show digit idx; bounded.
  task automatic wait_idx(int nd, int idx, string nm);
    bit found = 0;
    for (int k = 0; k < 64 && !found; k++) begin
      @(negedge clk);
      if (n >= 1 && ((n - 1) / 4) % nd == idx) found = 1;
    end
    check_int({nm, "_reached"}, int'(found), 1);
  endtask

  typedef struct {
    bit          use5;
    bit          mode;
    logic [31:0] v;
    bit          blz;
    logic [7:0]  dp;
    int          idx;
    logic [7:0]  exp_an;
    logic [7:0]  exp_cath;
    string       name;
  } vec_t;

  vec_t vecs [10];

  function automatic vec_t mk(bit u5, bit md, logic [31:0] v, bit blz, logic [7:0] dp,
                              int idx, logic [7:0] ea, logic [7:0] ec, string nm);
    vec_t r;
    r.use5 = u5; r.mode = md; r.v = v; r.blz = blz; r.dp = dp;
    r.idx = idx; r.exp_an = ea; r.exp_cath = ec; r.name = nm;
    return r;
  endfunction

  initial begin
    int cnt;
    rst = 1'b1; value = 0; load8 = 0; load5 = 0; mode_bcd = 0;
    blank_lz = 0; dp_mask = 0; blink_mask = 0;

    vecs[0] = mk(0, 0, 32'h1234ABCD, 0, 8'h00, 0, 8'hFE, 8'b10000101, "hex_d0");
    vecs[1] = mk(0, 0, 32'h1234ABCD, 0, 8'h00, 7, 8'h7F, 8'b10011111, "hex_d7");
    vecs[2] = mk(0, 1, 32'd12345,    1, 8'h00, 0, 8'hFE, 8'b01001001, "bcd_d0");
    vecs[3] = mk(0, 1, 32'd12345,    1, 8'h00, 4, 8'hEF, 8'b10011111, "bcd_d4");
    vecs[4] = mk(0, 1, 32'd12345,    1, 8'h00, 5, 8'hFF, 8'b00000011, "bcd_lz5");
    vecs[5] = mk(0, 1, 32'd100000000, 1, 8'h00, 3, 8'hF7, 8'b11111101, "ovf_d3");
    vecs[6] = mk(0, 1, 32'd7,        1, 8'h00, 0, 8'hFE, 8'b00011111, "ovf_clr");
    vecs[7] = mk(0, 0, 32'h0,        0, 8'h04, 2, 8'hFB, 8'b00000010, "dp_d2");
    vecs[8] = mk(1, 1, 32'd99999,    0, 8'h00, 4, 8'h0F, 8'b00001001, "d5_top");
    vecs[9] = mk(1, 1, 32'd99999,    0, 8'h00, 0, 8'h1E, 8'b00001001, "d5_wrap");

    // Reset state.
    repeat (3) @(negedge clk);
    check8("reset_an8", an8, 8'hFF);
    check8("reset_cath8", cath8, 8'hFF);
    check8("reset_busy8", {7'd0, busy8}, 8'd0);
    check8("reset_an5", {3'b000, an5}, 8'h1F);
    rst = 1'b0;

    // Directed vector table.
    foreach (vecs[i]) begin
      do_load(vecs[i].use5, vecs[i].mode, vecs[i].v, vecs[i].blz, vecs[i].dp, 8'h00);
      wait_idx(vecs[i].use5 ? 5 : 8, vecs[i].idx, vecs[i].name);
      if (vecs[i].use5) check8({vecs[i].name, "_an"}, {3'b000, an5}, vecs[i].exp_an);
      else              check8({vecs[i].name, "_an"}, an8, vecs[i].exp_an);
      check8({vecs[i].name, "_cath"}, vecs[i].use5 ? cath5 : cath8, vecs[i].exp_cath);
      scan_check(vecs[i].use5, 24, vecs[i].name);
    end

    // Full scans: hex stepping and 5-digit wrap.
    do_load(0, 0, 32'h1234ABCD, 0, 8'h00, 8'h00);
    scan_check(0, 40, "hex_scan");
    scan_check(1, 30, "d5_scan");

    // Decimal point and blink.
    do_load(0, 0, 32'h00000000, 0, 8'h04, 8'h01);
    scan_check(0, 80, "blink");

    // A load during conversion is dropped.
    @(negedge clk);
    mode_bcd = 1; value = 32'd12345; blank_lz = 1; dp_mask = 0; blink_mask = 0; load8 = 1;
    @(negedge clk);
    load8 = 0;
    cnt = 0;
    for (int k = 0; k < 100 && busy8; k++) begin
      cnt++;
      if (k == 3) begin load8 = 1; mode_bcd = 0; value = 32'h55; end
      else load8 = 0;
      @(negedge clk);
    end
    load8 = 0;
    check_int("busy_ignored_load", cnt, 33);
    repeat (2) @(negedge clk);
    exp_disp8 = to_bcd(12345, 8); exp_ovf8 = 0;
    scan_check(0, 40, "ignored_load");

    // Reset in the middle of a conversion.
    @(negedge clk);
    mode_bcd = 1; value = 32'd12345; load8 = 1;
    @(negedge clk);
    load8 = 0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check8("midrst_busy", {7'd0, busy8}, 8'd0);
    check8("midrst_an", an8, 8'hFF);
    check8("midrst_cath", cath8, 8'hFF);
    @(negedge clk);
    rst = 1'b0;
    exp_disp8 = 0; exp_ovf8 = 0; exp_disp5 = 0; exp_ovf5 = 0;
    wait_idx(8, 0, "post_rst");
    check8("post_rst_an", an8, 8'hFE);
    check8("post_rst_cath", cath8, 8'b00000011);
    scan_check(0, 40, "post_rst");

    // Random loads against the model.
    for (int r = 0; r < 14; r++) begin
      bit u5 = $urandom_range(0, 1) == 1;
      bit md = $urandom_range(0, 1) == 1;
      logic [31:0] v;
      case ($urandom_range(0, 3))
        0: v = $urandom_range(0, 999);
        1: v = $urandom_range(0, 99999);
        2: v = $urandom_range(0, 99999999);
        default: v = $urandom;
      endcase
      do_load(u5, md, v, $urandom_range(0, 1) == 1, 8'($urandom), 8'($urandom));
      scan_check(u5, 48, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ssd_scan_ctrl.md
Name: ssd_scan_ctrl

Overview:
Parametrised multi-digit seven-segment display controller; successor to the fixed 4-digit hex scan logic in the board top levels. Captures a value on a load strobe and shows it as hex, or as decimal through an on-block sequential binary-to-BCD converter. Scans N digits with a configurable dwell and drives active-low anodes and cathodes directly to board pins. Adds leading-zero blanking, per-digit decimal point, per-digit blink, and BCD overflow indication.

Parameters:
NUM_DIGITS, 8, digits driven (1..8); value width VW = 4*NUM_DIGITS
SCAN_DIV_BITS, 18, digit dwell = 2^SCAN_DIV_BITS clocks
BLINK_DIV_BITS, 26, blink half-period = 2^BLINK_DIV_BITS clocks

Ports:
ClkPort  in  1  system clock (100 MHz)
Reset  in  1  asynchronous, active-high
value  in  VW  binary (BCD mode) or packed hex nibbles (hex mode); nibble 0 = digit 0 (rightmost)
load  in  1  single-cycle capture strobe
mode_bcd  in  1  1 = decimal, 0 = hex; sampled with load
blank_lz  in  1  1 = blank leading zeros (live, not latched)
dp_mask  in  NUM_DIGITS  bit i lights Dp of digit i (live)
blink_mask  in  NUM_DIGITS  bit i blinks digit i (live)
busy  out  1  BCD conversion in progress
An  out  NUM_DIGITS  anodes, active-low, one-hot low
Cath  out  8  {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}, active-low

Behaviour:
- Reset (async): An all 1, Cath 8'hFF, busy 0, display register 0, overflow flag 0, digit index 0, scan and blink counters 0, converter IDLE.
- Capture: load with busy=0 latches value and mode_bcd. A load with busy=1 is ignored (no queueing).
- Hex mode: display register updated on the clock edge after load; busy stays 0.
- BCD mode: converter FSM IDLE -> SHIFT (VW cycles, double-dabble: add 3 to every digit >=5, then shift left one bit) -> COMMIT (1 cycle) -> IDLE.
  - busy is high from the cycle after load through COMMIT: VW+1 cycles.
  - In COMMIT, the display register and overflow flag update atomically. Old digits stay on display throughout the conversion.
- Overflow: set if a 1 shifts out of the top BCD digit during any SHIFT step. While set, every enabled digit shows a dash (Cath 8'b11111101, plus Dp per dp_mask). Cleared by any subsequent commit.
- Scan:
  - Free-running SCAN_DIV_BITS prescaler; digit index advances when the prescaler wraps to 0.
  - Index wraps from NUM_DIGITS-1 to 0; non-power-of-2 digit counts are supported.
- Outputs: An and Cath are registered together, one cycle after the index changes. There must be no cycle in which a new anode is driven with the old cathodes.
- Leading-zero blanking: when blank_lz=1, digits above the highest nonzero digit have their anode forced high. Digit 0 is never blanked (value 0 shows "0"). No blanking while overflow is set.
- Blink: the blink phase toggles every 2^BLINK_DIV_BITS clocks. When phase=1, digits with their blink_mask bit set have the anode forced high.
- Segment encoding (abcdefg,Dp), active-low:
  - 0 = 0000001x, 1 = 1001111x, 2 = 0010010x, 3 = 0000110x, 4 = 1001100x, 5 = 0100100x, 6 = 0100000x, 7 = 0001111x
  - 8 = 0000000x, 9 = 0000100x, A = 0001000x, B = 1100000x, C = 0110001x, D = 1000010x, E = 0110000x, F = 0111000x
  - x = ~dp_mask[index]
- Reset mid-conversion: the conversion is aborted, busy drops immediately, and the display shows 0 (blanked digits still blanked).

Decomposition:
- Package ssd_pkg:
  - Segment encoding function hex_to_seg(4-bit) returning the 7-bit pattern.
  - Constants SEG_DASH = 7'b1111110 and SEG_BLANK = 7'b1111111.
  - Converter state typedef (IDLE, SHIFT, COMMIT).
- Sub-module bin2bcd_seq:
  - Parametrised on NUM_DIGITS.
  - Ports start/value/busy/done/bcd/overflow.
  - Owns the SHIFT counter and digit adjust.
- Top keeps capture, scan, blanking and output registers.

Test Plan:
- NUM_DIGITS=8, SCAN_DIV_BITS=2, hex load 32'h1234ABCD -> An steps FE,FD,…,7F every 4 clocks; digit0 Cath 8'b10000101, digit7 Cath 8'b10011111.
- BCD load 32'd12345, blank_lz=1 -> busy high exactly 33 cycles; digits 0..4 show 5,4,3,2,1; An bits 5..7 never low.
- BCD load 32'd100000000 -> overflow; all 8 digits Cath 8'b11111101. A following load of 32'd7 clears it: digit0 = 8'b00011111.
- NUM_DIGITS=5, VW=20, BCD load 20'd99999 -> digits 0..4 show 9 with no overflow; index wraps 4->0 (An 5'b01111 -> 5'b11110).
- Load 0x55 during busy -> ignored, original result committed. Assert Reset mid-SHIFT -> busy=0, An all 1, Cath 8'hFF. After release, digit0 shows "0".
- dp_mask=8'h04, blink_mask=8'h01, BLINK_DIV_BITS=4 -> digit2 Dp=0; digit0 anode suppressed during alternate 16-clock phases.
